// File: rtl/alu_serial_sequencer_if.sv
// Host-side bus of the serial ALU sequencer: the operation request
// (start/cmd/operands) and the completion status (busy/done/result/flags).
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  // Requester side: issues operations and watches for completion.
  modport master (
    output start, cmd, operand_a, operand_b,
    input  busy, done, result, carryout, overflow, zero
  );

  // Sequencer side: accepts operations and reports results.
  modport slave (
    input  start, cmd, operand_a, operand_b,
    output busy, done, result, carryout, overflow, zero
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Serial ALU sequencer: computes a WIDTH-bit ALU operation by feeding an
// external 1-bit ALU slice one bit per clock, LSB first. Owns the operand
// shift registers, the carry chain register, the bit counter, the SLT
// fix-up and the result flags. A request takes WIDTH RUN cycles followed
// by a single DONE cycle; a new request may be accepted in DONE.
module alu_serial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_serial_sequencer_if.slave bus,
  output logic                 slice_a,
  output logic                 slice_b,
  output logic                 slice_cin,
  output logic [2:0]           slice_cmd,
  input  logic                 slice_result,
  input  logic                 slice_cout
);

  // Operation encoding shared with the external bit slice.
  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  // Counter wide enough to index bits 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;

  logic [WIDTH-1:0] aSr;
  logic [WIDTH-1:0] bSr;
  logic [WIDTH-1:0] resSr;
  logic             carryReg;
  logic [CNT_W-1:0] bitCnt;
  logic [2:0]       cmdReg;

  logic [WIDTH-1:0] resultReg;
  logic             carryoutReg;
  logic             overflowReg;

  logic             accept;
  logic             lastBit;
  logic             newInvertsB;
  logic             latchedArith;
  logic             latchedSlt;
  logic             finalOvf;
  logic             sltBit;
  logic [WIDTH-1:0] finalSr;

  // A request is only looked at when no operation is in flight.
  assign accept  = bus.start && ((state == IDLE) || (state == DONE));
  assign lastBit = (state == RUN) && (bitCnt == LAST_BIT);

  // Subtract-style operations start the carry chain at 1 (A + ~B + 1);
  // the slice itself performs the B inversion.
  assign newInvertsB  = (bus.cmd == CMD_SUB) || (bus.cmd == CMD_SLT);
  assign latchedArith = (cmdReg == CMD_ADD) || (cmdReg == CMD_SUB);
  assign latchedSlt   = (cmdReg == CMD_SLT);

  // Values seen on the MSB cycle: signed overflow is the carry into the
  // sign bit differing from the carry out of it. SLT is "A-B is negative",
  // corrected for overflow.
  assign finalOvf = slice_cin ^ slice_cout;
  assign sltBit   = slice_result ^ finalOvf;
  assign finalSr  = {slice_result, resSr[WIDTH-1:1]};

  // Slice drive: always the low bits of the shift registers, so the
  // outputs stay defined (never X) in IDLE/DONE.
  assign slice_a   = aSr[0];
  assign slice_b   = bSr[0];
  assign slice_cin = carryReg;
  assign slice_cmd = cmdReg;

  // Host-side status.
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.result   = resultReg;
  assign bus.carryout = carryoutReg;
  assign bus.overflow = overflowReg;
  assign bus.zero     = (resultReg == '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (lastBit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Operand capture and per-bit shifting of operands, partial result and carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aSr      <= '0;
      bSr      <= '0;
      resSr    <= '0;
      carryReg <= 1'b0;
      bitCnt   <= '0;
      cmdReg   <= CMD_ADD;
    end else if (accept) begin
      aSr      <= bus.operand_a;
      bSr      <= bus.operand_b;
      resSr    <= '0;
      carryReg <= newInvertsB;
      bitCnt   <= '0;
      cmdReg   <= bus.cmd;
    end else if (state == RUN) begin
      aSr      <= aSr >> 1;
      bSr      <= bSr >> 1;
      resSr    <= finalSr;
      carryReg <= slice_cout;
      bitCnt   <= bitCnt + 1'b1;
    end
  end

  // Published result and flags: written only on the edge entering DONE so
  // the partial result never shows on the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resultReg   <= '0;
      carryoutReg <= 1'b0;
      overflowReg <= 1'b0;
    end else if (lastBit) begin
      if (latchedSlt) begin
        resultReg <= {{(WIDTH-1){1'b0}}, sltBit};
      end else begin
        resultReg <= finalSr;
      end
      carryoutReg <= latchedArith ? slice_cout : 1'b0;
      overflowReg <= latchedArith ? finalOvf : 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for the serial ALU sequencer. A behavioural model of the
// 1-bit ALU slice closes the loop; expected results are hand-computed.
module tb_alu_serial_sequencer;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sliceA, sliceB, sliceCin;
  logic [2:0] sliceCmd;
  logic sliceResult, sliceCout;
  logic bEff;

  int errors = 0;
  int checks = 0;
  int cyc;
  int busyCyc;
  int donePulses;

  alu_serial_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .slice_a      (sliceA),
    .slice_b      (sliceB),
    .slice_cin    (sliceCin),
    .slice_cmd    (sliceCmd),
    .slice_result (sliceResult),
    .slice_cout   (sliceCout)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice (inverts B for SUB/SLT).
  always_comb begin
    bEff = sliceB ^ ((sliceCmd == 3'd1) || (sliceCmd == 3'd3));
    sliceCout = (sliceA & bEff) | (sliceA & sliceCin) | (bEff & sliceCin);
    case (sliceCmd)
      3'd2:    sliceResult = sliceA ^ sliceB;
      3'd4:    sliceResult = sliceA & sliceB;
      3'd5:    sliceResult = ~(sliceA & sliceB);
      3'd6:    sliceResult = ~(sliceA | sliceB);
      3'd7:    sliceResult = sliceA | sliceB;
      default: sliceResult = sliceA ^ bEff ^ sliceCin;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; it is accepted on the next rising edge.
  task automatic startOp(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.cmd = c;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called one cycle after acceptance; counts cycles until done (bounded).
  task automatic waitDone(output int nCyc, output int nBusy);
    nCyc = 1;
    nBusy = bus.busy ? 1 : 0;
    while (!bus.done && nCyc < 200) begin
      @(negedge clk);
      nCyc++;
      if (bus.busy) nBusy++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes,
                       input logic expC, input logic expV);
    int n;
    int nb;
    startOp(c, a, b);
    waitDone(n, nb);
    chk({tag, " latency"}, n, 33);
    chk({tag, " busy cycles"}, nb, 32);
    chk({tag, " result"}, bus.result, expRes);
    chk({tag, " carryout"}, {31'd0, bus.carryout}, {31'd0, expC});
    chk({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, expV});
    chk({tag, " zero"}, {31'd0, bus.zero}, {31'd0, (expRes == 32'd0)});
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " result held"}, bus.result, expRes);
    $display("op %s: cmd=%0d a=0x%h b=0x%h result=0x%h c=%b v=%b z=%b", tag, c, a, b,
             bus.result, bus.carryout, bus.overflow, bus.zero);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cmd = 3'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset zero", {31'd0, bus.zero}, 32'd1);
    chk("reset carryout", {31'd0, bus.carryout}, 32'd0);
    chk("reset overflow", {31'd0, bus.overflow}, 32'd0);
    chk("reset slice_cin", {31'd0, sliceCin}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Arithmetic
    runOp("add ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    runOp("sub eq", 3'd1, 32'd5, 32'd5, 32'h00000000, 1'b1, 1'b0);
    runOp("add wrap", 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    runOp("sub neg", 3'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
    runOp("sub ovf", 3'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Set-less-than
    runOp("slt ovf", 3'd3, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    runOp("slt ge", 3'd3, 32'd3, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b0);
    runOp("slt lt", 3'd3, 32'hFFFFFFFE, 32'd3, 32'h00000001, 1'b0, 1'b0);

    // Logic ops
    runOp("nand", 3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0);
    runOp("and", 3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    runOp("or", 3'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    runOp("nor", 3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0);
    runOp("xor", 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);

    // start held through RUN with churning inputs, then back-to-back op
    bus.start = 1'b1;
    bus.cmd = 3'd0;
    bus.operand_a = 32'd1;
    bus.operand_b = 32'd2;
    @(negedge clk);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      bus.cmd = 3'(cyc);
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      @(negedge clk);
      cyc++;
    end
    chk("hold latency", cyc, 33);
    chk("hold result", bus.result, 32'd3);
    chk("hold carryout", {31'd0, bus.carryout}, 32'd0);
    $display("op hold: cmd=0 a=0x1 b=0x2 result=0x%h", bus.result);
    bus.cmd = 3'd1;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd30;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b done low", {31'd0, bus.done}, 32'd0);
    chk("b2b result stable", bus.result, 32'd3);
    waitDone(cyc, busyCyc);
    chk("b2b latency", cyc, 33);
    chk("b2b result", bus.result, 32'd70);
    chk("b2b carryout", {31'd0, bus.carryout}, 32'd1);
    $display("op b2b: cmd=1 a=0x64 b=0x1e result=0x%h c=%b", bus.result, bus.carryout);
    @(negedge clk);

    // Reset mid-RUN at bit 10
    startOp(3'd0, 32'h0000FFFF, 32'h00000001);
    for (int i = 1; i < 11; i++) @(negedge clk);
    chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid reset busy", {31'd0, bus.busy}, 32'd0);
    chk("mid reset done", {31'd0, bus.done}, 32'd0);
    chk("mid reset result", bus.result, 32'd0);
    chk("mid reset zero", {31'd0, bus.zero}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) donePulses++;
    end
    chk("no done after abort", donePulses, 0);
    runOp("post reset", 3'd0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
